// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a start/busy/done handshake and HI/LO result registers.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   a_orig;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy   = (state == CALC);
    assign done   = (state == DONE);
    assign accept = start && (state != CALC);

    always_comb begin
        a_neg = op[0] & a[WIDTH-1];
        b_neg = op[0] & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;

        // Multiply: acc holds {partial product, remaining multiplier bits}.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

        // Divide: acc[WIDTH-1:0] shifts dividend out and quotient bits in.
        // The true difference always fits WIDTH bits, so only the low word is kept.
        div_shift = {rem, acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;

        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        quo_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            b_zero      <= 1'b0;
            a_orig      <= '0;
            opnd        <= '0;
            acc         <= '0;
            rem         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state       <= CALC;
                        cnt         <= '0;
                        is_div      <= op[1];
                        neg_res     <= a_neg ^ b_neg;
                        neg_rem     <= a_neg;
                        b_zero      <= (b == '0);
                        a_orig      <= a;
                        opnd        <= op[1] ? b_mag : a_mag;
                        acc         <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                        rem         <= '0;
                        div_by_zero <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (cnt == CW'(WIDTH)) begin
                        // Extra cycle after the last bit applies signs and the b==0 override.
                        state <= DONE;
                        if (!is_div) begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end else if (b_zero) begin
                            hi          <= a_orig;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (!is_div) begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end else begin
                            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
                            rem            <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint sx, sy, q, r;
        logic [63:0] p;
        ez = 1'b0;
        case (o)
            2'b00: begin
                p  = {32'b0, x} * {32'b0, y};
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = 64'(sx * sy);
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    eh = x;
                    el = 32'hFFFF_FFFF;
                    ez = 1'b1;
                end else begin
                    if (o == 2'b10) begin
                        sx = longint'({32'b0, x});
                        sy = longint'({32'b0, y});
                    end else begin
                        sx = longint'($signed(x));
                        sy = longint'($signed(y));
                    end
                    q  = sx / sy;
                    r  = sx % sy;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
        endcase
    endfunction

    // Starts an op at the current cycle and waits for done (bounded).
    // Returns the number of edges after the start edge at which done was seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rh, output logic [31:0] rl, output logic rz,
                          output int lat);
        int n;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        rh  = hi;
        rl  = lo;
        rz  = div_by_zero;
        lat = n;
    endtask

    task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] x,
                            input logic [31:0] y);
        logic [31:0] rh, rl, eh, el;
        logic rz, ez;
        int lat;
        ref_calc(o, x, y, eh, el, ez);
        run_op(o, x, y, rh, rl, rz, lat);
        checks++;
        if (lat !== W + 1 || busy !== 1'b0 || rh !== eh || rl !== el || rz !== ez) begin
            failures++;
            $display("FAIL %s op=%0d a=%h b=%h: lat=%0d busy=%b hi=%h lo=%h dbz=%b want lat=%0d busy=0 hi=%h lo=%h dbz=%b",
                     name, o, x, y, lat, busy, rh, rl, rz, W + 1, eh, el, ez);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h dbz=%b want all 0",
                     busy, done, hi, lo, div_by_zero);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed;
        check_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7);
        check_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2);
        check_op("divu_zero", 2'b10, 32'd100, 32'd0);
        check_op("after_zero", 2'b10, 32'd100, 32'd7);
        check_op("div_zero_signed", 2'b11, 32'h8000_0005, 32'd0);
        check_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("div_rem_neg", 2'b11, 32'd7, 32'hFFFF_FFFE);
        check_op("mult_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000);
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start;
        logic [31:0] eh, el;
        logic ez;
        int n;
        ref_calc(2'b00, 32'd12345, 32'd6789, eh, el, ez);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd12345;
        b     = 32'd6789;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b1;
        op    = 2'b11;
        a     = 32'hDEAD_BEEF;
        b     = 32'd3;
        @(posedge clk);
        #1;
        n++;
        start = 1'b0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== W + 1 || hi !== eh || lo !== el || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start: lat=%0d hi=%h lo=%h dbz=%b want lat=%0d hi=%h lo=%h dbz=0",
                     n, hi, lo, div_by_zero, W + 1, eh, el);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start_idle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back;
        check_op("b2b_first", 2'b01, 32'h1234_5678, 32'hFEDC_BA98);
        check_op("b2b_second", 2'b10, 32'hFFFF_0000, 32'd77);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op;
        int seen;
        start = 1'b1;
        op    = 2'b11;
        a     = 32'h7654_3210;
        b     = 32'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h dbz=%b want all 0",
                     busy, done, hi, lo, div_by_zero);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL no_done_after_reset: active cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_random;
        logic [31:0] x, y;
        logic [1:0] o;
        for (int i = 0; i < 1000; i++) begin
            o = 2'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                2: y = 32'hFFFF_FFFF;
                3: x = 32'h8000_0000;
                default: ;
            endcase
            check_op("random", o, x, y);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid_op;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
